// File: rtl/mem_bus_decoder.sv
// Address decoder between one master and NR_SLAVES slaves with in-order read tracking,
// void-access handling, a response timeout and sticky error flags.
module mem_bus_decoder #(
  parameter int unsigned                 NR_SLAVES       = 4,
  parameter logic [32*NR_SLAVES-1:0]     SLAVE_BASE      = {32'hf001_0000, 32'hf000_0000,
                                                            32'h0001_0000, 32'h0000_0000},
  parameter logic [32*NR_SLAVES-1:0]     SLAVE_MASK      = {32'hffff_0000, 32'hffff_0000,
                                                            32'hffff_0000, 32'hffff_e000},
  parameter int unsigned                 MAX_OUTSTANDING = 2,
  parameter int unsigned                 TIMEOUT_CYCLES  = 255,
  parameter logic [31:0]                 VOID_RDATA      = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      m_cmd_valid,
  output logic                      m_cmd_ready,
  input  logic                      m_cmd_wr,
  input  logic [31:0]               m_cmd_addr,
  input  logic [31:0]               m_cmd_wdata,
  input  logic [3:0]                m_cmd_be,
  output logic                      m_rsp_ready,
  output logic [31:0]               m_rsp_rdata,

  output logic [NR_SLAVES-1:0]      s_cmd_valid,
  output logic                      s_cmd_wr,
  output logic [31:0]               s_cmd_addr,
  output logic [31:0]               s_cmd_wdata,
  output logic [3:0]                s_cmd_be,
  input  logic [NR_SLAVES-1:0]      s_cmd_ready,
  input  logic [NR_SLAVES-1:0]      s_rsp_ready,
  input  logic [32*NR_SLAVES-1:0]   s_rsp_rdata,

  output logic                      err_void,
  output logic                      err_timeout,
  output logic                      err_stray
);

  localparam int unsigned          OWNER_W     = $clog2(NR_SLAVES + 1);
  localparam logic [OWNER_W-1:0]   VOID_IDX    = OWNER_W'(NR_SLAVES);
  localparam logic [3:0]           MAX_CNT     = 4'(MAX_OUTSTANDING);
  localparam logic [15:0]          TIMER_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]          TIMEOUT_RDATA = 32'hdead_beef;

  logic [3:0]           count_q, count_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [15:0]          timer_q, timer_d;
  logic                 void_rsp_q, void_rsp_d;
  logic                 err_void_q, err_void_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 err_stray_q, err_stray_d;

  logic [OWNER_W-1:0]   hit_idx;
  logic [NR_SLAVES-1:0] hit_sel;
  logic                 hit_found;
  logic                 hit_void;
  logic                 sel_cmd_ready;
  logic                 read_ok;
  logic                 issuable;
  logic                 cmd_fire;
  logic                 rd_fire;

  logic [NR_SLAVES-1:0] owner_sel;
  logic [31:0]          owner_rdata;
  logic                 busy;
  logic                 owner_void;
  logic                 slave_rsp;
  logic                 void_rsp;
  logic                 rsp_retire;
  logic                 timeout;
  logic                 retire;
  logic                 stray;

  assign s_cmd_wr    = m_cmd_wr;
  assign s_cmd_addr  = m_cmd_addr;
  assign s_cmd_wdata = m_cmd_wdata;
  assign s_cmd_be    = m_cmd_be;

  // Lowest-index match wins; no match leaves hit_idx at the void index.
  always_comb begin
    hit_idx   = VOID_IDX;
    hit_sel   = '0;
    hit_found = 1'b0;
    for (int i = 0; i < int'(NR_SLAVES); i++) begin
      if (!hit_found &&
          ((m_cmd_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32])) begin
        hit_found  = 1'b1;
        hit_idx    = OWNER_W'(i);
        hit_sel[i] = 1'b1;
      end
    end
  end

  assign hit_void      = ~hit_found;
  assign sel_cmd_ready = hit_void | (|(s_cmd_ready & hit_sel));

  assign busy     = (count_q != 4'd0);
  assign read_ok  = (count_q < MAX_CNT) && (!busy || (hit_idx == owner_q));
  assign issuable = m_cmd_wr | read_ok;

  assign s_cmd_valid = (m_cmd_valid && issuable) ? hit_sel : '0;
  assign m_cmd_ready = sel_cmd_ready & issuable;
  assign cmd_fire    = m_cmd_valid & m_cmd_ready;
  assign rd_fire     = cmd_fire & ~m_cmd_wr;

  always_comb begin
    owner_sel   = '0;
    owner_rdata = '0;
    for (int i = 0; i < int'(NR_SLAVES); i++) begin
      if (owner_q == OWNER_W'(i)) begin
        owner_sel[i] = 1'b1;
        owner_rdata  = s_rsp_rdata[32*i +: 32];
      end
    end
  end

  assign owner_void = (owner_q == VOID_IDX);
  assign slave_rsp  = busy & (|(s_rsp_ready & owner_sel));
  assign void_rsp   = busy & owner_void & void_rsp_q;
  assign rsp_retire = slave_rsp | void_rsp;
  // Fire on the cycle the timer would reach the limit, so the timeout lands exactly
  // TIMEOUT_CYCLES cycles after the read was accepted; a real response wins.
  assign timeout    = busy & ~rsp_retire & (timer_q == TIMER_LIMIT);
  assign retire     = rsp_retire | timeout;
  assign stray      = |(s_rsp_ready & ~(busy ? owner_sel : '0));

  assign m_rsp_ready = retire;

  always_comb begin
    m_rsp_rdata = '0;
    if (busy) begin
      if (timeout) begin
        m_rsp_rdata = TIMEOUT_RDATA;
      end else if (owner_void) begin
        m_rsp_rdata = VOID_RDATA;
      end else begin
        m_rsp_rdata = owner_rdata;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({rd_fire, retire})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    owner_d       = rd_fire ? hit_idx : owner_q;
    timer_d       = (!busy || retire) ? 16'd0 : timer_q + 16'd1;
    void_rsp_d    = rd_fire & hit_void;
    err_void_d    = err_void_q | (cmd_fire & hit_void);
    err_timeout_d = err_timeout_q | timeout;
    err_stray_d   = err_stray_q | stray;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      owner_q       <= '0;
      timer_q       <= '0;
      void_rsp_q    <= 1'b0;
      err_void_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_stray_q   <= 1'b0;
    end else begin
      count_q       <= count_d;
      owner_q       <= owner_d;
      timer_q       <= timer_d;
      void_rsp_q    <= void_rsp_d;
      err_void_q    <= err_void_d;
      err_timeout_q <= err_timeout_d;
      err_stray_q   <= err_stray_d;
    end
  end

  assign err_void    = err_void_q;
  assign err_timeout = err_timeout_q;
  assign err_stray   = err_stray_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Bench for mem_bus_decoder: directed scenarios followed by random traffic, all compared
// against a queue-based model of outstanding reads.
module tb_mem_bus_decoder;

  localparam int NS   = 4;
  localparam int MAXO = 2;
  localparam int TO   = 8;
  localparam logic [31:0] VOIDD = 32'h0000_0000;
  localparam logic [31:0] BASE_A [4] = '{32'h0000_0000, 32'h0001_0000,
                                         32'hf000_0000, 32'hf001_0000};
  localparam logic [31:0] MASK_A [4] = '{32'hffff_e000, 32'hffff_0000,
                                         32'hffff_0000, 32'hffff_0000};

  logic          clk = 1'b0;
  logic          reset;
  logic          m_cmd_valid, m_cmd_ready, m_cmd_wr;
  logic [31:0]   m_cmd_addr, m_cmd_wdata;
  logic [3:0]    m_cmd_be;
  logic          m_rsp_ready;
  logic [31:0]   m_rsp_rdata;
  logic [3:0]    s_cmd_valid;
  logic          s_cmd_wr;
  logic [31:0]   s_cmd_addr, s_cmd_wdata;
  logic [3:0]    s_cmd_be;
  logic [3:0]    s_cmd_ready, s_rsp_ready;
  logic [127:0]  s_rsp_rdata;
  logic          err_void, err_timeout, err_stray;

  always #5 clk = ~clk;

  mem_bus_decoder #(
    .NR_SLAVES      (NS),
    .SLAVE_BASE     ({BASE_A[3], BASE_A[2], BASE_A[1], BASE_A[0]}),
    .SLAVE_MASK     ({MASK_A[3], MASK_A[2], MASK_A[1], MASK_A[0]}),
    .MAX_OUTSTANDING(MAXO),
    .TIMEOUT_CYCLES (TO),
    .VOID_RDATA     (VOIDD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m_cmd_valid(m_cmd_valid),
    .m_cmd_ready(m_cmd_ready),
    .m_cmd_wr   (m_cmd_wr),
    .m_cmd_addr (m_cmd_addr),
    .m_cmd_wdata(m_cmd_wdata),
    .m_cmd_be   (m_cmd_be),
    .m_rsp_ready(m_rsp_ready),
    .m_rsp_rdata(m_rsp_rdata),
    .s_cmd_valid(s_cmd_valid),
    .s_cmd_wr   (s_cmd_wr),
    .s_cmd_addr (s_cmd_addr),
    .s_cmd_wdata(s_cmd_wdata),
    .s_cmd_be   (s_cmd_be),
    .s_cmd_ready(s_cmd_ready),
    .s_rsp_ready(s_rsp_ready),
    .s_rsp_rdata(s_rsp_rdata),
    .err_void   (err_void),
    .err_timeout(err_timeout),
    .err_stray  (err_stray)
  );

  int checks = 0;
  int errors = 0;

  // Model: queue of targets of reads in flight, cycles waited since the last retire.
  int pend[$];
  int waited   = 0;
  bit void_due = 1'b0;
  bit m_err_void = 1'b0, m_err_to = 1'b0, m_err_stray = 1'b0;
  bit e_retire, e_fire, e_stray, e_timeout;
  int e_target;

  function automatic int target_of(logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & MASK_A[i]) == BASE_A[i]) return i;
    end
    return NS;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    int cnt, own, tgt;
    bit iss, rdy, sret, vret;
    logic [3:0] exp_v;
    logic [31:0] rd;
    #3;
    cnt  = pend.size();
    own  = (cnt > 0) ? pend[0] : -1;
    tgt  = target_of(m_cmd_addr);
    iss  = m_cmd_wr || (cnt < MAXO && (cnt == 0 || tgt == own));
    exp_v = (m_cmd_valid && tgt < NS && iss) ? 4'(1 << tgt) : 4'b0000;
    rdy  = (tgt < NS) ? (s_cmd_ready[tgt] && iss) : iss;
    sret = 1'b0;
    if (cnt > 0 && own < NS) sret = s_rsp_ready[own];
    vret = (cnt > 0) && (own == NS) && void_due;
    e_timeout = (cnt > 0) && !sret && !vret && (waited == TO - 1);
    e_retire  = sret || vret || e_timeout;
    if (cnt == 0)          rd = 32'h0;
    else if (e_timeout)    rd = 32'hdead_beef;
    else if (own == NS)    rd = VOIDD;
    else                   rd = s_rsp_rdata[32*own +: 32];
    e_stray = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (s_rsp_ready[i] && (cnt == 0 || i != own)) e_stray = 1'b1;
    end
    e_fire   = m_cmd_valid && rdy;
    e_target = tgt;
    chk("s_cmd_valid", s_cmd_valid, exp_v);
    chk("m_cmd_ready", m_cmd_ready, rdy);
    chk("m_rsp_ready", m_rsp_ready, e_retire);
    chk("m_rsp_rdata", m_rsp_rdata, rd);
    chk("s_cmd_addr", s_cmd_addr, m_cmd_addr);
    chk("s_cmd_wdata", s_cmd_wdata, m_cmd_wdata);
    chk("s_cmd_wr_be", {s_cmd_wr, s_cmd_be}, {m_cmd_wr, m_cmd_be});
    chk("err_void", err_void, m_err_void);
    chk("err_timeout", err_timeout, m_err_to);
    chk("err_stray", err_stray, m_err_stray);
  endtask

  task automatic tick();
    int cnt0;
    @(posedge clk);
    if (reset) begin
      pend.delete();
      waited = 0;
      void_due = 1'b0;
      m_err_void = 1'b0;
      m_err_to = 1'b0;
      m_err_stray = 1'b0;
    end else begin
      cnt0 = pend.size();
      waited = (cnt0 == 0 || e_retire) ? 0 : waited + 1;
      if (e_retire) void'(pend.pop_front());
      void_due = 1'b0;
      if (e_fire) begin
        if (e_target == NS) m_err_void = 1'b1;
        if (!m_cmd_wr) begin
          pend.push_back(e_target);
          if (e_target == NS) void_due = 1'b1;
        end
      end
      if (e_timeout) m_err_to = 1'b1;
      if (e_stray) m_err_stray = 1'b1;
    end
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic cmd(bit v, bit wr, logic [31:0] addr);
    m_cmd_valid = v;
    m_cmd_wr    = wr;
    m_cmd_addr  = addr;
    m_cmd_wdata = $urandom;
    m_cmd_be    = 4'($urandom);
  endtask

  task automatic idle();
    m_cmd_valid = 1'b0;
    m_cmd_wr    = 1'b0;
    s_rsp_ready = 4'b0000;
  endtask

  logic [31:0] addr_r;
  logic [3:0]  rr;

  initial begin
    reset = 1'b1;
    cmd(1'b0, 1'b0, 32'h0);
    s_cmd_ready = 4'b1111;
    s_rsp_ready = 4'b0000;
    s_rsp_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst_svalid", s_cmd_valid, 4'b0000);
    chk("rst_rsp", m_rsp_ready, 1'b0);
    tick();
    reset = 1'b0;

    // Single read to slave 0, answered two cycles later.
    cmd(1'b1, 1'b0, 32'h0000_0010);
    settle();
    chk("rd0_sel", s_cmd_valid, 4'b0001);
    chk("rd0_acc", m_cmd_ready, 1'b1);
    tick();
    idle();
    step();
    s_rsp_ready = 4'b0001;
    s_rsp_rdata[31:0] = 32'h1234_5678;
    settle();
    chk("rd0_rsp", m_rsp_ready, 1'b1);
    chk("rd0_data", m_rsp_rdata, 32'h1234_5678);
    tick();
    s_rsp_ready = 4'b0000;
    settle();
    chk("rd0_done", m_rsp_ready, 1'b0);
    chk("rd0_zero", m_rsp_rdata, 32'h0);
    tick();

    // Outstanding limit: third read to slave 2 held until a retire.
    cmd(1'b1, 1'b0, 32'hf000_0004);
    settle(); chk("lim_acc1", m_cmd_ready, 1'b1); tick();
    settle(); chk("lim_acc2", m_cmd_ready, 1'b1); tick();
    settle(); chk("lim_hold", m_cmd_ready, 1'b0); tick();
    s_rsp_ready = 4'b0100;
    s_rsp_rdata[95:64] = $urandom;
    settle();
    chk("lim_rsp1", m_rsp_ready, 1'b1);
    chk("lim_hold2", m_cmd_ready, 1'b0);
    tick();
    s_rsp_ready = 4'b0000;
    settle(); chk("lim_acc3", m_cmd_ready, 1'b1); tick();
    idle();
    s_rsp_ready = 4'b0100;
    step();
    step();
    s_rsp_ready = 4'b0000;
    step();

    // Owner ordering: read to slave 1 stalls behind slave 0, a write does not.
    cmd(1'b1, 1'b0, 32'h0000_0020);
    settle(); chk("own_acc0", m_cmd_ready, 1'b1); tick();
    cmd(1'b1, 1'b0, 32'h0001_0040);
    settle();
    chk("own_stall", m_cmd_ready, 1'b0);
    chk("own_nosel", s_cmd_valid, 4'b0000);
    tick();
    cmd(1'b1, 1'b1, 32'h0001_0040);
    settle();
    chk("own_wr", m_cmd_ready, 1'b1);
    chk("own_wsel", s_cmd_valid, 4'b0010);
    tick();
    cmd(1'b1, 1'b0, 32'h0001_0040);
    s_rsp_ready = 4'b0001;
    settle();
    chk("own_rsp0", m_rsp_ready, 1'b1);
    chk("own_stall2", m_cmd_ready, 1'b0);
    tick();
    s_rsp_ready = 4'b0000;
    settle(); chk("own_acc1", m_cmd_ready, 1'b1); tick();
    idle();
    s_rsp_ready = 4'b0010;
    s_rsp_rdata[63:32] = 32'hcafe_f00d;
    settle();
    chk("own_rsp1", m_rsp_ready, 1'b1);
    chk("own_data1", m_rsp_rdata, 32'hcafe_f00d);
    tick();
    s_rsp_ready = 4'b0000;
    step();

    // Void read.
    cmd(1'b1, 1'b0, 32'h8000_0000);
    settle();
    chk("void_acc", m_cmd_ready, 1'b1);
    chk("void_nosel", s_cmd_valid, 4'b0000);
    tick();
    idle();
    settle();
    chk("void_rsp", m_rsp_ready, 1'b1);
    chk("void_data", m_rsp_rdata, VOIDD);
    chk("void_err", err_void, 1'b1);
    tick();
    step();

    // Timeout on slave 3, then a late response is stray.
    cmd(1'b1, 1'b0, 32'hf001_0000);
    settle(); chk("to_acc", m_cmd_ready, 1'b1); tick();
    idle();
    for (int k = 1; k < TO; k++) begin
      settle();
      chk("to_wait", m_rsp_ready, 1'b0);
      tick();
    end
    settle();
    chk("to_fire", m_rsp_ready, 1'b1);
    chk("to_data", m_rsp_rdata, 32'hdead_beef);
    tick();
    settle(); chk("to_err", err_timeout, 1'b1); tick();
    s_rsp_ready = 4'b1000;
    step();
    s_rsp_ready = 4'b0000;
    settle(); chk("to_stray", err_stray, 1'b1); tick();

    // Reset with two reads outstanding.
    cmd(1'b1, 1'b0, 32'h0000_0030);
    step();
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cmd(1'b1, 1'b0, 32'h0000_0030);
    settle();
    chk("rst2_void", err_void, 1'b0);
    chk("rst2_to", err_timeout, 1'b0);
    chk("rst2_stray", err_stray, 1'b0);
    chk("rst2_zero", m_rsp_rdata, 32'h0);
    chk("rst2_acc", m_cmd_ready, 1'b1);
    tick();
    idle();
    s_rsp_ready = 4'b0001;
    step();
    s_rsp_ready = 4'b0000;
    step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom % 5)
        0: addr_r = $urandom & 32'h0000_1fff;
        1: addr_r = 32'h0001_0000 | ($urandom & 32'h0000_ffff);
        2: addr_r = 32'hf000_0000 | ($urandom & 32'h0000_ffff);
        3: addr_r = 32'hf001_0000 | ($urandom & 32'h0000_ffff);
        default: addr_r = 32'h8000_0000 | ($urandom & 32'h0fff_ffff);
      endcase
      cmd(($urandom % 10) < 7, ($urandom % 10) < 3, addr_r);
      s_cmd_ready = 4'($urandom) | 4'($urandom);
      rr = 4'b0000;
      if (pend.size() > 0 && pend[0] < NS && ($urandom % 3) == 0) rr[pend[0]] = 1'b1;
      if (($urandom % 25) == 0) rr[$urandom % 4] = 1'b1;
      s_rsp_ready = rr;
      s_rsp_rdata = {$urandom, $urandom, $urandom, $urandom};
      reset = (($urandom % 250) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
